// File: rtl/fa_bist_checker_if.sv
// fa_bist_checker_if: the sweep control and status signals, plus the full-adder
// connection between the checker (master) and the adder/controller side (slave).
`default_nettype none

interface fa_bist_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       carryIn;
    logic       sum;
    logic       carryOut;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail;

    modport master (
        input  start, sum, carryOut,
        output a, b, carryIn, busy, done, pass, err_count, first_fail
    );

    modport slave (
        output start, sum, carryOut,
        input  a, b, carryIn, busy, done, pass, err_count, first_fail
    );
endinterface

`default_nettype wire

// File: rtl/fa_bist_checker.sv
// fa_bist_checker: sweeps all 8 input vectors through an external full adder,
// lets each vector settle, then counts mismatches and captures the first failing vector.
`default_nettype none

module fa_bist_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    fa_bist_checker_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // APPLY loads the down-counter, so a load of N-1 gives exactly N SETTLE cycles.
    localparam logic [3:0] c_settle_load = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_vec;
    logic [3:0] r_settle_cnt;
    logic [3:0] r_err_count;
    logic [2:0] r_first_fail;
    logic       r_pass;
    logic       w_busy;
    logic       w_done;
    logic       w_exp_sum;
    logic       w_exp_cout;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = APPLY;
                end
            end
            APPLY: begin
                w_busy       = 1'b1;
                w_next_state = (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
            end
            SETTLE: begin
                w_busy = 1'b1;
                if (r_settle_cnt == 4'd0) begin
                    w_next_state = CHECK;
                end
            end
            CHECK: begin
                w_busy       = 1'b1;
                w_next_state = (r_vec == 3'd7) ? DONE : APPLY;
            end
            DONE: begin
                w_done       = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Reference full adder evaluated on the vector currently driven out.
    always_comb begin
        w_exp_sum  = r_vec[2] ^ r_vec[1] ^ r_vec[0];
        w_exp_cout = (r_vec[2] & r_vec[1]) | (r_vec[0] & (r_vec[2] ^ r_vec[1]));
        w_mismatch = (bus.sum != w_exp_sum) || (bus.carryOut != w_exp_cout);
        w_err_next = r_err_count + {3'b000, w_mismatch};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vec        <= 3'd0;
            r_settle_cnt <= 4'd0;
            r_err_count  <= 4'd0;
            r_first_fail <= 3'd0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_vec        <= 3'd0;
                        r_err_count  <= 4'd0;
                        r_first_fail <= 3'd0;
                        r_pass       <= 1'b0;
                    end
                end
                APPLY: begin
                    r_settle_cnt <= c_settle_load;
                end
                SETTLE: begin
                    if (r_settle_cnt != 4'd0) begin
                        r_settle_cnt <= r_settle_cnt - 4'd1;
                    end
                end
                CHECK: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && (r_err_count == 4'd0)) begin
                        r_first_fail <= r_vec;
                    end
                    // Vector returns to 0 after the last check so the operands idle low.
                    if (r_vec == 3'd7) begin
                        r_vec  <= 3'd0;
                        r_pass <= (w_err_next == 4'd0);
                    end else begin
                        r_vec <= r_vec + 3'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.a          = r_vec[2];
    assign bus.b          = r_vec[1];
    assign bus.carryIn    = r_vec[0];
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err_count;
    assign bus.first_fail = r_first_fail;

endmodule

`default_nettype wire
